stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control stage between the debounced buttons and the BCD digit counter chain of the stopwatch.
- Edge-detects the four debounced button levels.
- Runs the run/lap/stop/idle state machine.
- Generates the single-cycle 0.1 s count enable and the counter clear.
- Holds the displayed digits during lap mode before they reach the seven-segment driver.
- Replaces the free-running toggled clock with a proper clock enable on clk.

Parameters:
MAX_COUNT, 5000000, clk cycles per 0.1 s tick (50 MHz clk).
CNT_W, 23, prescaler width; must satisfy 2**CNT_W >= MAX_COUNT.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high system reset
start_e  input  1  debounced start button level
reset_e  input  1  debounced reset button level
pause_e  input  1  debounced pause (lap) button level
stopp_e  input  1  debounced stop button level
digit0..digit3  input  4 each  live BCD digits from counter chain (digit0 = 0.1 s)
tick_en  output  1  one-cycle count enable for digit0 counter
count_clr  output  1  one-cycle synchronous clear for counter chain
disp0..disp3  output  4 each  digits to seven-segment driver
state  output  2  IDLE=0, RUN=1, LAP=2, STOP=3
running  output  1  high in RUN or LAP

Behaviour:
- Reset values while reset=1: state=IDLE, prescaler=0, tick_en=0, count_clr=0, disp0..3=0. Edge-detect history registers reset to 1, so a button held through reset does not fire.
- Edge detect: an event is level=1 and previous=0, registered each cycle. The event acts on the state in the same cycle it is detected. There is one cycle of latency from input rise to state change.
- Simultaneous events: priority is reset_e > stopp_e > start_e > pause_e. Only the highest-priority event is acted on; the others are dropped.
- Transitions:
  - reset_e event, any state: -> IDLE, count_clr=1 next cycle, prescaler <= 0.
  - stopp_e event: RUN or LAP -> STOP. Ignored in IDLE and STOP.
  - start_e event: IDLE, STOP or LAP -> RUN. Ignored in RUN.
  - pause_e event: RUN -> LAP, LAP -> RUN. Ignored in IDLE and STOP.
- Prescaler:
  - In RUN or LAP: counts 0..MAX_COUNT-1, then wraps to 0. tick_en=1 for exactly the one cycle in which prescaler==MAX_COUNT-1.
  - In STOP: holds its value, so a resume keeps the sub-tick fraction.
  - In IDLE: held at 0.
  - tick_en is never asserted in IDLE or STOP, nor in the cycle a stop event is taken.
- count_clr: registered one-cycle pulse, only on a reset_e event. tick_en=0 in the same cycle.
- Display:
  - disp registers load digit0..3 every cycle except in LAP, where they hold. Latency is 1 cycle from digit input to disp.
  - On RUN->LAP, the disp value is the value loaded in the cycle the pause event was detected.
  - On LAP->STOP or LAP->RUN, disp resumes live loading the next cycle.
- running = (state==RUN) or (state==LAP), combinational from the state register.
- Digit wrap from 9999 to 0000 is handled by the counter chain. This block does not react to it.
- Reset mid-count: all internal state is discarded immediately. No tick is issued in the reset cycle.

Decomposition:
- Shared package: state encoding constants (ST_IDLE/ST_RUN/ST_LAP/ST_STOP) and the MAX_COUNT default, for reuse by top-level and bench.
- One natural sub-module: edge_rise (1-bit rising-edge detector, history reset to 1), instantiated four times.
- FSM, prescaler and display hold stay in stopwatch_ctrl.

Test Plan:
- MAX_COUNT=4. Reset, then pulse start_e: state=1 after 1 cycle; tick_en high every 4th cycle; first tick 4 cycles after entering RUN.
- In RUN with digits driven 0x0123, pulse pause_e: state=2; disp stays 0123 while digits change to 0456; pause_e again gives disp=0456 one cycle later.
- RUN with prescaler at 2: pulse stopp_e, wait 10 cycles, pulse start_e: no tick_en during STOP; first tick 2 cycles after RUN re-entry.
- In RUN, raise start_e, stopp_e and reset_e in the same cycle: state=IDLE, count_clr pulses exactly 1 cycle, tick_en stays 0.
- Hold pause_e=1 through reset release, then pulse start_e: no LAP entry. Pause in IDLE or STOP is ignored (state unchanged).
- Assert reset while in LAP with prescaler=3: next cycle state=0, disp=0, tick_en=0, count_clr=0.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control stage.
// Contents:
//   sw_state_t     - FSM state encoding (IDLE=0, RUN=1, LAP=2, STOP=3)
//   MAX_COUNT_DEF  - clk cycles per 0.1 s tick at 50 MHz
//   CNT_W_DEF      - prescaler width that holds MAX_COUNT_DEF-1
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } sw_state_t;

  localparam int MAX_COUNT_DEF = 5000000;
  localparam int CNT_W_DEF     = 23;

endpackage

// File: rtl/stopwatch_ctrl_edge_rise.sv
// edge_rise: 1-bit rising-edge detector for a debounced button level.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   level - debounced button level
//   rise  - high for one cycle when level is 1 and was 0 last cycle
// The history register resets to 1 so a button held through reset
// does not produce an event when reset is released.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= 1'b1;
    end else begin
      prev_reg <= level;
    end
  end

  assign rise = level & ~prev_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control stage between debounced buttons and the BCD
// counter chain. Detects button edges, runs the IDLE/RUN/LAP/STOP FSM,
// produces the 0.1 s count enable and counter clear, and freezes the
// displayed digits while in LAP.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   start_e/reset_e/pause_e/stopp_e - debounced button levels
//   digit0..digit3              - live BCD digits (digit0 = 0.1 s)
//   tick_en                     - one-cycle count enable for digit0
//   count_clr                   - one-cycle clear for the counter chain
//   disp0..disp3                - digits to the seven-segment driver
//   state                       - IDLE=0, RUN=1, LAP=2, STOP=3
//   running                     - high in RUN or LAP
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int MAX_COUNT = MAX_COUNT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_e,
  input  logic       reset_e,
  input  logic       pause_e,
  input  logic       stopp_e,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic       tick_en,
  output logic       count_clr,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [3:0] disp3,
  output logic [1:0] state,
  output logic       running
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(MAX_COUNT - 1);

  // Button order: 0=start, 1=reset, 2=pause, 3=stop
  logic [3:0] btn_lvl;
  logic [3:0] btn_rise;
  assign btn_lvl = {stopp_e, pause_e, reset_e, start_e};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      edge_rise u_edge (
        .clk   (clk),
        .reset (reset),
        .level (btn_lvl[gi]),
        .rise  (btn_rise[gi])
      );
    end
  endgenerate

  logic ev_start, ev_reset, ev_pause, ev_stop;
  assign ev_start = btn_rise[0];
  assign ev_reset = btn_rise[1];
  assign ev_pause = btn_rise[2];
  assign ev_stop  = btn_rise[3];

  logic [3:0] digit_in [4];
  assign digit_in[0] = digit0;
  assign digit_in[1] = digit1;
  assign digit_in[2] = digit2;
  assign digit_in[3] = digit3;

  sw_state_t        state_reg, state_next;
  logic [CNT_W-1:0] presc_reg, presc_next;
  logic             clr_reg, clr_next;
  logic             tick_next;
  logic [3:0]       disp_reg  [4];
  logic [3:0]       disp_next [4];
  logic             counting;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      presc_reg <= '0;
      clr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      clr_reg   <= clr_next;
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_disp
      always_ff @(posedge clk) begin
        if (reset) begin
          disp_reg[gi] <= 4'd0;
        end else begin
          disp_reg[gi] <= disp_next[gi];
        end
      end
    end
  endgenerate

  assign counting = (state_reg == ST_RUN) || (state_reg == ST_LAP);

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    clr_next   = 1'b0;
    tick_next  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // LAP freezes the display; every other state follows the counters.
      disp_next[i] = (state_reg == ST_LAP) ? disp_reg[i] : digit_in[i];
    end

    // Only the highest-priority event is acted on; lower ones are dropped
    // even when the winning event is ignored in the current state.
    if (ev_reset) begin
      state_next = ST_IDLE;
      presc_next = '0;
      clr_next   = 1'b1;
    end else if (ev_stop) begin
      // Prescaler holds through the stop so a resume keeps the fraction.
      if (counting) begin
        state_next = ST_STOP;
      end
    end else begin
      if (ev_start) begin
        if (state_reg != ST_RUN) begin
          state_next = ST_RUN;
        end
      end else if (ev_pause) begin
        if (state_reg == ST_RUN) begin
          state_next = ST_LAP;
        end else if (state_reg == ST_LAP) begin
          state_next = ST_RUN;
        end
      end

      if (counting) begin
        if (presc_reg == PRESC_LAST) begin
          tick_next  = 1'b1;
          presc_next = '0;
        end else begin
          presc_next = presc_reg + CNT_W'(1);
        end
      end else if (state_reg == ST_IDLE) begin
        presc_next = '0;
      end
    end
  end

  assign tick_en   = tick_next & ~reset;
  assign count_clr = clr_reg;
  assign disp0     = disp_reg[0];
  assign disp1     = disp_reg[1];
  assign disp2     = disp_reg[2];
  assign disp3     = disp_reg[3];
  assign state     = state_reg;
  assign running   = counting;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with MAX_COUNT=4.
// Stimulus pushes the hand-computed expected outputs for a cycle into a
// queue; a monitor on the falling edge pops entries due that cycle and
// compares them against the DUT. A field of -1 means "not checked".
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_e, reset_e, pause_e, stopp_e;
  logic [15:0] dig;
  logic        tick_en, count_clr, running;
  logic [3:0]  disp0, disp1, disp2, disp3;
  logic [1:0]  state;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MAX_COUNT(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_e   (start_e),
    .reset_e   (reset_e),
    .pause_e   (pause_e),
    .stopp_e   (stopp_e),
    .digit0    (dig[3:0]),
    .digit1    (dig[7:4]),
    .digit2    (dig[11:8]),
    .digit3    (dig[15:12]),
    .tick_en   (tick_en),
    .count_clr (count_clr),
    .disp0     (disp0),
    .disp1     (disp1),
    .disp2     (disp2),
    .disp3     (disp3),
    .state     (state),
    .running   (running)
  );

  typedef struct {
    int          cyc;
    int          st;
    int          tk;
    int          clr;
    int          dsp;
    logic [63:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input logic [63:0] tag, input string what, input int act, input int req);
    if (req >= 0) begin
      checks++;
      if (act != req) begin
        errors++;
        $display("FAIL %0s %0s cyc=%0d got=%0h expected=%0h", tag, what, cyc, act, req);
      end
    end
  endtask

  // Monitor: compare every expectation scheduled for the current cycle.
  exp_t e;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %0s stale got_cyc=%0d expected_cyc=%0d", e.tag, cyc, e.cyc);
      end else begin
        cmp(e.tag, "state", int'(state), e.st);
        if (e.st >= 0)
          cmp(e.tag, "running", int'(running), (e.st == 1 || e.st == 2) ? 1 : 0);
        cmp(e.tag, "tick_en", int'(tick_en), e.tk);
        cmp(e.tag, "count_clr", int'(count_clr), e.clr);
        cmp(e.tag, "disp", int'({disp3, disp2, disp1, disp0}), e.dsp);
      end
    end
  end

  task automatic chk(input logic [63:0] tag, input int st, input int tk, input int clr, input int dsp);
    exp_t x;
    x.cyc = cyc; x.st = st; x.tk = tk; x.clr = clr; x.dsp = dsp; x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start_e = 0; reset_e = 0; pause_e = 0; stopp_e = 0; dig = 16'h0000;
    adv(1);
    chk("rst", 0, 0, 0, 16'h0000); adv(1);

    // Leave reset, start counting.
    reset = 1'b0; dig = 16'h0123;
    chk("idle", 0, 0, 0, 16'h0000); adv(1);
    start_e = 1;
    chk("startev", 0, 0, 0, 16'h0123); adv(1);
    start_e = 0;
    for (int i = 0; i < 8; i++) begin
      chk("run", 1, (i % 4 == 3) ? 1 : 0, 0, 16'h0123); adv(1);
    end

    // Lap: display freezes at 0123 while digits move to 0456.
    pause_e = 1;
    chk("lapev", 1, 0, 0, 16'h0123); adv(1);
    pause_e = 0; dig = 16'h0456;
    chk("lap", 2, 0, 0, 16'h0123); adv(1);
    chk("lap", 2, 0, 0, 16'h0123); adv(1);
    chk("laptick", 2, 1, 0, 16'h0123); adv(1);
    pause_e = 1;
    chk("lapexit", 2, 0, 0, 16'h0123); adv(1);
    pause_e = 0;
    chk("relive", 1, 0, 0, -1); adv(1);

    // Stop with prescaler at 2, pause ignored in STOP, display live.
    stopp_e = 1;
    chk("stopev", 1, 0, 0, 16'h0456); adv(1);
    stopp_e = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) dig = 16'h0789;
      pause_e = (i == 3);
      chk("stop", 3, 0, 0, (i >= 2) ? 16'h0789 : -1); adv(1);
    end
    start_e = 1;
    chk("resume", 3, 0, 0, 16'h0789); adv(1);
    start_e = 0;
    chk("rerun", 1, 0, 0, -1); adv(1);
    chk("retick", 1, 1, 0, -1); adv(1);
    for (int i = 0; i < 3; i++) begin
      chk("run2", 1, 0, 0, -1); adv(1);
    end

    // Simultaneous start/stop/reset on a tick cycle: reset wins.
    start_e = 1; stopp_e = 1; reset_e = 1;
    chk("multi", 1, 0, 0, -1); adv(1);
    start_e = 0; stopp_e = 0; reset_e = 0;
    chk("clr", 0, 0, 1, -1); adv(1);
    pause_e = 1;
    chk("clrdone", 0, 0, 0, -1); adv(1);
    pause_e = 0;
    chk("idlepau", 0, 0, 0, -1); adv(1);

    // Buttons held through reset must not fire.
    reset = 1; start_e = 1; pause_e = 1;
    adv(1);
    chk("rst2", 0, 0, 0, 16'h0000); adv(1);
    reset = 0;
    chk("held", 0, 0, 0, -1); adv(1);
    start_e = 0;
    chk("held", 0, 0, 0, -1); adv(1);
    start_e = 1;
    chk("startb", 0, 0, 0, -1); adv(1);
    start_e = 0;
    chk("runb", 1, 0, 0, -1); adv(1);
    chk("runb", 1, 0, 0, -1); adv(1);
    pause_e = 0;
    chk("runb", 1, 0, 0, -1); adv(1);
    chk("tickb", 1, 1, 0, -1); adv(1);
    pause_e = 1;
    chk("lapevb", 1, 0, 0, 16'h0789); adv(1);
    pause_e = 0;
    chk("lapb", 2, 0, 0, 16'h0789); adv(1);
    dig = 16'h0321;
    chk("lapb", 2, 0, 0, 16'h0789); adv(1);

    // System reset in LAP with prescaler at 3: no tick in reset cycle.
    reset = 1;
    chk("rstlap", 2, 0, 0, 16'h0789); adv(1);
    reset = 0;
    chk("afterrs", 0, 0, 0, 16'h0000); adv(1);
    chk("live", 0, 0, 0, 16'h0321); adv(1);

    for (int w = 0; w < 50 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
